mux_pipe_skid: RTL and testbench
================================

// Module: mux_pipe_skid
// PURPOSE
//  Parametrised N-way, W-bit operand-select stage for the pipelined CPU; generalises the
//  fixed 2/4-input datapath muxes into a registered pipeline stage.
//  Selects one of N flattened inputs, then registers the result behind a valid/ready
//  handshake with a 2-entry skid buffer, giving full throughput and a registered in_ready.
//  Adds a one-hot select mode, illegal-select detection and a flush for branch/exception kill.
// PARAMETERS
//  W       32  data width per input
//  N       4   number of inputs (2..16)
//  ONEHOT  0   0: sel is binary, SW=clog2(N) bits; 1: sel is one-hot, SW=N bits
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  clr        in   1     asynchronous, active-high reset
//  flush      in   1     synchronous kill of all buffered entries
//  in_data    in   N*W   input a[i] = in_data[i*W +: W]
//  sel        in   SW    select (binary or one-hot per ONEHOT)
//  in_valid   in   1     upstream offers in_data/sel this cycle
//  in_ready   out  1     stage accepts this cycle (registered)
//  out_data   out  W     selected, registered data
//  out_valid  out  1     out_data is valid
//  out_ready  in   1     downstream accepts out_data this cycle
//  sel_err    out  1     sticky: an accepted beat carried an illegal select
// BEHAVIOUR
//  - Reset (clr=1, asynchronous): out_valid=0, out_data=0, in_ready=1, sel_err=0, skid empty.
//  - Accept when in_valid & in_ready; move when out_valid & out_ready; data never dropped or duplicated.
//  - Selection: binary: sel<N -> a[sel]; sel>=N -> 0. one-hot: exactly one bit set -> that
//    input; zero or multi-hot -> 0. Illegal select on an accepted beat sets sel_err; the
//    beat still propagates (data 0). sel_err clears only on clr.
//  - Latency: accepted beat appears on out_data/out_valid the following cycle (1 cycle).
//  - States: EMPTY (out_valid=0), ONE (out reg full, skid empty), FULL (both full).
//    EMPTY: accept -> ONE. ONE: accept&move -> ONE; accept&!move -> FULL; move only -> EMPTY.
//    FULL: in_ready=0; move -> ONE with skid contents moved to out reg; else hold.
//  - in_ready = (state != FULL), driven from a flop; never depends combinationally on out_ready.
//  - Output held stable (data and valid) while out_valid & !out_ready.
//  - flush: next state EMPTY, out_valid=0, in_ready=1; a beat offered in the flush cycle is
//    discarded; out_data value is don't-care after flush. flush with clr: clr wins.
//  - clr mid-transfer drops all buffered beats immediately (no completion).
//  - out_data and skid data are W-bit; no width extension or truncation of inputs.
// STRUCTURE
//  - mux_pkg: function clog2, SEL_BIN/SEL_ONEHOT mode constants, state encoding
//    (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2).
//  - Combinational N-way select + legality check in this module (generate over N).
//  - Sub-module skid_buf #(W+1): 2-entry valid/ready buffer carrying {sel_bad, data};
//    mux_pipe_skid instantiates one and owns sel_err.
// TESTING
//  1 Reset: assert clr async mid-cycle -> out_valid=0, in_ready=1, sel_err=0 without clock edge.
//  2 Streaming, N=4 binary: a0..a3=0x11,0x22,0x33,0x44, sel=0,1,2,3 back-to-back, out_ready=1
//    -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, one cycle after each accept.
//  3 Backpressure: out_ready=0 for 3 cycles while streaming -> two beats buffered, in_ready=0
//    from 3rd cycle, out_data frozen; release -> remaining beats in order, none lost.
//  4 Illegal select: N=3, sel=2'd3 accepted -> out_data=0, sel_err=1 and stays 1 afterwards.
//  5 ONEHOT=1, N=4: sel=4'b0100 -> a2; sel=4'b0110 -> 0 and sel_err=1; sel=0 -> 0, sel_err=1.
//  6 Flush in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed
//    and offered beats never appear on out_data.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the operand-select pipeline stage: select modes,
// skid-buffer state encoding and an elaboration-time log2 helper.
package mux_pkg;

    localparam int SEL_BIN    = 0;
    localparam int SEL_ONEHOT = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Smallest r with (1 << r) >= v; used to size the binary select.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Purpose: 2-entry valid/ready register slice (output register + skid register).
// Latency: 1 cycle from accept to out_vld.
// Backpressure: in_rdy is a flop, low only when both entries are full.
module skid_buf
    import mux_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         flush,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_rdy_q, in_rdy_d;
    logic         acc;
    logic         mv;

    assign out_vld = (state_q != ST_EMPTY);
    assign out_dat = out_q;
    assign in_rdy  = in_rdy_q;
    assign acc     = in_vld & in_rdy_q;
    assign mv      = out_vld & out_rdy;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    out_d   = in_dat;
                end
            end
            ST_ONE: begin
                if (acc && mv) begin
                    out_d = in_dat;
                end else if (acc) begin
                    state_d = ST_FULL;
                    skid_d  = in_dat;
                end else if (mv) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (mv) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Kill drops every buffered entry and the beat offered this cycle.
        if (flush) begin
            state_d = ST_EMPTY;
        end
        in_rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_EMPTY;
            out_q    <= '0;
            skid_q   <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            skid_q   <= skid_d;
            in_rdy_q <= in_rdy_d;
        end
    end

endmodule

// File: rtl/mux_pipe_skid.sv
// Purpose: N-way W-bit operand select (binary or one-hot) feeding a 2-entry skid slice.
// Latency: 1 cycle.  Backpressure: registered in_ready, full throughput, sticky sel_err.
module mux_pipe_skid
    import mux_pkg::*;
#(
    parameter  int W      = 32,
    parameter  int N      = 4,
    parameter  int ONEHOT = SEL_BIN,
    localparam int SW     = (ONEHOT == SEL_ONEHOT) ? N : clog2(N)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           flush,
    input  logic [N*W-1:0] in_data,
    input  logic [SW-1:0]  sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sel_err
);

    logic [N-1:0] hit;
    logic [W-1:0] mux_dat;
    logic         sel_bad;
    logic         accept;
    logic [W:0]   buf_out;
    logic         sel_err_q, sel_err_d;

    // One comparator per input; an illegal code matches none of them.
    for (genvar gi = 0; gi < N; gi++) begin : g_hit
        localparam logic [SW-1:0] CODE = (ONEHOT == SEL_ONEHOT) ? (SW'(1) << gi) : SW'(gi);
        assign hit[gi] = (sel == CODE);
    end

    always_comb begin
        mux_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (hit[i]) begin
                mux_dat = mux_dat | in_data[i*W +: W];
            end
        end
        sel_bad = ~|hit;
    end

    skid_buf #(
        .W (W + 1)
    ) u_skid (
        .clk     (clk),
        .clr     (clr),
        .flush   (flush),
        .in_dat  ({sel_bad, mux_dat}),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .out_dat (buf_out),
        .out_vld (out_valid),
        .out_rdy (out_ready)
    );

    assign out_data = buf_out[W-1:0];
    assign accept   = in_valid & in_ready & ~flush;

    // Flag sets on the accepting edge; the carried bit keeps it coherent with the output beat.
    always_comb begin
        sel_err_d = sel_err_q | (accept & sel_bad) | (out_valid & buf_out[W]);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_pipe_skid.sv
// Directed bench for mux_pipe_skid: three instances (N=4 binary, N=3 binary, N=4 one-hot)
// with a per-instance expected-data queue checked whenever a beat leaves the stage.
module tb_mux_pipe_skid;

    logic clk;
    logic clr;

    // N=4 binary instance
    logic [31:0] b_in;
    logic [1:0]  b_sel;
    logic        b_iv, b_ir, b_ov, b_or, b_err, b_flush;
    logic [7:0]  b_od;
    // N=3 binary instance
    logic [23:0] n_in;
    logic [1:0]  n_sel;
    logic        n_iv, n_ir, n_ov, n_or, n_err;
    logic [7:0]  n_od;
    // N=4 one-hot instance
    logic [31:0] o_in;
    logic [3:0]  o_sel;
    logic        o_iv, o_ir, o_ov, o_or, o_err;
    logic [7:0]  o_od;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] qb[$];
    logic [7:0] qn[$];
    logic [7:0] qo[$];

    mux_pipe_skid #(.W(8), .N(4), .ONEHOT(0)) u_bin (
        .clk(clk), .clr(clr), .flush(b_flush), .in_data(b_in), .sel(b_sel),
        .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od), .out_valid(b_ov),
        .out_ready(b_or), .sel_err(b_err)
    );

    mux_pipe_skid #(.W(8), .N(3), .ONEHOT(0)) u_n3 (
        .clk(clk), .clr(clr), .flush(1'b0), .in_data(n_in), .sel(n_sel),
        .in_valid(n_iv), .in_ready(n_ir), .out_data(n_od), .out_valid(n_ov),
        .out_ready(n_or), .sel_err(n_err)
    );

    mux_pipe_skid #(.W(8), .N(4), .ONEHOT(1)) u_oh (
        .clk(clk), .clr(clr), .flush(1'b0), .in_data(o_in), .sel(o_sel),
        .in_valid(o_iv), .in_ready(o_ir), .out_data(o_od), .out_valid(o_ov),
        .out_ready(o_or), .sel_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_b(input logic [1:0] s);
        return b_in[s*8 +: 8];
    endfunction

    function automatic logic [7:0] exp_n(input logic [1:0] s);
        if (s < 2'd3) return n_in[s*8 +: 8];
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_o(input logic [3:0] s);
        if ($countones(s) != 1) return 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) return o_in[i*8 +: 8];
        end
        return 8'h00;
    endfunction

    // Scoreboard: push model result on accept, pop and compare on each output transfer.
    always @(negedge clk) begin
        if (clr) begin
            qb.delete();
            qn.delete();
            qo.delete();
        end else begin
            if (b_flush) begin
                qb.delete();
            end else begin
                if (b_ov && b_or) begin
                    if (qb.size() == 0) check("b_unexpected_valid", b_ov, 0);
                    else check("b_data", b_od, qb.pop_front());
                end
                if (b_iv && b_ir) qb.push_back(exp_b(b_sel));
            end
            if (n_ov && n_or) begin
                if (qn.size() == 0) check("n_unexpected_valid", n_ov, 0);
                else check("n_data", n_od, qn.pop_front());
            end
            if (n_iv && n_ir) qn.push_back(exp_n(n_sel));
            if (o_ov && o_or) begin
                if (qo.size() == 0) check("o_unexpected_valid", o_ov, 0);
                else check("o_data", o_od, qo.pop_front());
            end
            if (o_iv && o_ir) qo.push_back(exp_o(o_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [1:0] s);
        bit ok;
        ok = 1'b0;
        b_sel = s;
        b_iv = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = b_ir;
            tick();
        end
        b_iv = 1'b0;
        check("b_accept", 32'(ok), 1);
    endtask

    task automatic send_n(input logic [1:0] s);
        bit ok;
        ok = 1'b0;
        n_sel = s;
        n_iv = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = n_ir;
            tick();
        end
        n_iv = 1'b0;
        check("n_accept", 32'(ok), 1);
    endtask

    task automatic send_o(input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        o_sel = s;
        o_iv = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = o_ir;
            tick();
        end
        o_iv = 1'b0;
        check("o_accept", 32'(ok), 1);
    endtask

    initial begin
        logic [7:0] lat_exp [4];
        lat_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

        clr = 1'b1;
        b_in = 32'h44332211; b_sel = '0; b_iv = 0; b_or = 1; b_flush = 0;
        n_in = 24'h332211;   n_sel = '0; n_iv = 0; n_or = 1;
        o_in = 32'hDDCCBBAA; o_sel = '0; o_iv = 0; o_or = 1;
        tick();
        tick();
        check("rst_out_valid", b_ov, 0);
        check("rst_in_ready", b_ir, 1);
        check("rst_out_data", b_od, 0);
        check("rst_sel_err", b_err, 0);
        clr = 1'b0;
        tick();

        // Back-to-back streaming with one-cycle latency
        b_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_sel = 2'(i);
            tick();
            check("stream_latency_data", b_od, lat_exp[i]);
            check("stream_latency_valid", b_ov, 1);
        end
        b_iv = 1'b0;
        tick();
        tick();
        check("stream_drained", b_ov, 0);

        // Backpressure: out_ready low for three cycles
        b_or = 1'b0;
        b_iv = 1'b1;
        b_sel = 2'd0;
        tick();
        b_sel = 2'd1;
        tick();
        check("bp_in_ready_low", b_ir, 0);
        check("bp_frozen_data", b_od, 8'h11);
        b_sel = 2'd2;
        tick();
        check("bp_in_ready_still_low", b_ir, 0);
        check("bp_frozen_data2", b_od, 8'h11);
        check("bp_valid_held", b_ov, 1);
        b_or = 1'b1;
        send_b(2'd2);
        send_b(2'd3);
        repeat (4) tick();
        check("bp_all_delivered", qb.size(), 0);
        check("bp_idle", b_ov, 0);

        // Illegal binary select on N=3
        check("n3_err_clear", n_err, 0);
        send_n(2'd1);
        check("n3_legal_data", n_od, 8'h22);
        send_n(2'd3);
        check("n3_illegal_data", n_od, 8'h00);
        check("n3_err_set", n_err, 1);
        send_n(2'd0);
        tick();
        check("n3_err_sticky", n_err, 1);

        // One-hot select
        send_o(4'b0100);
        check("oh_legal_data", o_od, 8'hCC);
        check("oh_err_clear", o_err, 0);
        send_o(4'b0110);
        check("oh_multihot_data", o_od, 8'h00);
        check("oh_err_set", o_err, 1);
        send_o(4'b0000);
        check("oh_zero_data", o_od, 8'h00);
        send_o(4'b1000);
        check("oh_legal_after_err", o_od, 8'hDD);
        check("oh_err_sticky", o_err, 1);
        repeat (2) tick();

        // Flush while FULL with a beat offered
        b_or = 1'b0;
        b_iv = 1'b1;
        b_sel = 2'd0;
        tick();
        b_sel = 2'd1;
        tick();
        check("fl_full", b_ir, 0);
        b_flush = 1'b1;
        b_sel = 2'd3;
        tick();
        b_flush = 1'b0;
        b_iv = 1'b0;
        check("fl_out_valid", b_ov, 0);
        check("fl_in_ready", b_ir, 1);
        b_or = 1'b1;
        repeat (3) tick();
        check("fl_nothing_emerges", b_ov, 0);
        send_b(2'd2);
        check("fl_recover_data", b_od, 8'h33);
        repeat (2) tick();
        check("fl_queue_empty", qb.size(), 0);

        // Asynchronous reset mid-cycle with a beat buffered
        b_or = 1'b0;
        send_b(2'd0);
        check("ar_pre_valid", b_ov, 1);
        #3;
        clr = 1'b1;
        #1;
        check("ar_out_valid", b_ov, 0);
        check("ar_in_ready", b_ir, 1);
        check("ar_out_data", b_od, 0);
        check("ar_n3_sel_err", n_err, 0);
        check("ar_oh_sel_err", o_err, 0);
        tick();
        clr = 1'b0;
        b_or = 1'b1;
        tick();
        tick();
        check("ar_no_completion", b_ov, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
